key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the register read bus.
REQ-002 Parameter KEY_WIDTH, default 6, SHALL set the number of keys (KEY_WIDTH <= DATA_WIDTH).
REQ-003 Parameter DEBOUNCE_CYCLES, default 65536, SHALL set the consecutive stable samples required (minimum 2).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 key_n  input  KEY_WIDTH  SHALL carry synchronized, active-low key levels (0 = pressed); no further synchronization inside.
REQ-007 clr_events  input  1  SHALL, when high for one cycle, clear the press-event latch.
REQ-008 key_level  output  KEY_WIDTH  SHALL give the debounced level, active-high (1 = pressed).
REQ-009 key_press  output  KEY_WIDTH  SHALL pulse high for one cycle per debounced press.
REQ-010 key_release  output  KEY_WIDTH  SHALL pulse high for one cycle per debounced release.
REQ-011 data  output signed  DATA_WIDTH  SHALL equal {zero fill, press-event latch}, combinational from registers.

Function
REQ-012 Each key SHALL run an independent 4-state FSM: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
REQ-013 raw_pressed SHALL be ~key_n[i]; all comparisons SHALL use raw_pressed.
REQ-014 RELEASED with raw_pressed=1 SHALL go to PRESS_PENDING with counter loaded to 1.
REQ-015 PRESS_PENDING with raw_pressed=1 SHALL increment the counter; on the edge where counter == DEBOUNCE_CYCLES-1 it SHALL go to PRESSED, set key_level[i]=1, pulse key_press[i].
REQ-016 PRESS_PENDING with raw_pressed=0 SHALL return to RELEASED with counter cleared and no pulse.
REQ-017 PRESSED / RELEASE_PENDING SHALL mirror REQ-014..016 with raw_pressed=0, clearing key_level[i] and pulsing key_release[i].
REQ-018 Latency: a clean input change held from sampling edge k SHALL update key_level and pulse on edge k+DEBOUNCE_CYCLES-1 (DEBOUNCE_CYCLES samples total).
REQ-019 key_level, key_press, key_release SHALL be registered and change on the same edge.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no level change and no pulse.
REQ-021 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap (max value DEBOUNCE_CYCLES-1).
REQ-022 Press-event latch bit i SHALL be set by key_press[i] and held until cleared.
REQ-023 clr_events coincident with key_press[i] SHALL leave bit i set (set wins); other bits clear.
REQ-024 Keys pressed on the same edge SHALL each pulse independently in that cycle.

Reset
REQ-025 reset SHALL force every FSM to RELEASED, all counters to 0, key_level/key_press/key_release to 0, latch to 0 (data = 0).
REQ-026 A key held pressed through reset release SHALL be reported via a full DEBOUNCE_CYCLES qualification after reset deasserts.
REQ-027 reset mid-count SHALL discard partial counts without emitting pulses.

Structure
REQ-028 FSM state encodings and the counter-width function SHALL live in a shared include/package used by the input blocks.
REQ-029 One sub-module, key_debounce_bit (one key: FSM + counter + pulses), SHALL be instantiated KEY_WIDTH times via generate; the latch stays in the top.

Verification (bench uses DEBOUNCE_CYCLES=4, KEY_WIDTH=6)
REQ-030 key_n[0] 1->0 held 10 cycles -> key_level[0]=1 and key_press[0] single pulse 3 edges after first low sample; data=8'h01.
REQ-031 key_n[1] low for 3 samples then high -> no pulse, key_level=0, data=0.
REQ-032 Key 0 released after 20 cycles -> key_release[0] single pulse 3 edges later, data still 8'h01; clr_events -> data=0 next cycle.
REQ-033 clr_events asserted on the key_press[2] edge -> data=8'h04 afterwards.
REQ-034 reset asserted after 2 low samples on key 3 -> no pulse; held low after reset -> press pulse 3 edges after reset drops.
REQ-035 key_n=6'b000000 from 6'b111111 on same edge -> all six key_press bits pulse same cycle; data=8'h3F.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: per-key state encoding and counter sizing.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'd0,
        ST_PRESS_PENDING   = 2'd1,
        ST_PRESSED         = 2'd2,
        ST_RELEASE_PENDING = 2'd3
    } key_state_e;

    // Counter only needs to reach cycles-1, so $clog2(cycles) bits suffice (never below 1).
    function automatic int cnt_width(input int cycles);
        if (cycles < 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One-key debouncer: four-state FSM with a qualification counter and registered level/pulse outputs.
//
// state              | meaning
// ST_RELEASED        | debounced level is released, input agrees
// ST_PRESS_PENDING   | input reads pressed, counting consecutive pressed samples
// ST_PRESSED         | debounced level is pressed, input agrees
// ST_RELEASE_PENDING | input reads released, counting consecutive released samples
module key_debounce_bit
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_pressed,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (raw_pressed) begin
                    state_d = ST_PRESS_PENDING;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_PENDING: begin
                if (!raw_pressed) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!raw_pressed) begin
                    state_d = ST_RELEASE_PENDING;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_PENDING: begin
                if (raw_pressed) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one key_debounce_bit per key plus a sticky press-event latch on the read bus.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int KEY_WIDTH       = 6,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [KEY_WIDTH-1:0]         key_n,
    input  logic                         clr_events,
    output logic [KEY_WIDTH-1:0]         key_level,
    output logic [KEY_WIDTH-1:0]         key_press,
    output logic [KEY_WIDTH-1:0]         key_release,
    output logic signed [DATA_WIDTH-1:0] data
);

    logic [KEY_WIDTH-1:0] raw_pressed;
    logic [KEY_WIDTH-1:0] latch_q, latch_d;

    assign raw_pressed = ~key_n;

    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
        key_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk          (clk),
            .reset        (reset),
            .raw_pressed  (raw_pressed[i]),
            .level        (key_level[i]),
            .press_pulse  (key_press[i]),
            .release_pulse(key_release[i])
        );
    end

    // A press landing on the same edge as a clear must survive it.
    always_comb begin
        latch_d = latch_q | key_press;
        if (clr_events) begin
            latch_d = key_press;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    always_comb begin
        data                = '0;
        data[KEY_WIDTH-1:0] = latch_q;
    end

endmodule
